// File: rtl/fir_decim_sink.sv
// fir_decim_sink: keeps one of every N strobed input samples, rounds, shifts and
// saturates each kept sample, and buffers it in a small FIFO drained by valid/ready.
module fir_decim_sink #(
    parameter int unsigned IN_W       = 32,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned SHIFT      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             m_clk,
    input  logic             rst,
    input  logic [3:0]       decim,
    input  logic             data_in_en,
    input  logic [IN_W-1:0]  data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             drop,
    output logic             ovf_flag,
    output logic             sat_flag,
    input  logic             clr_flags
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // Half-LSB rounding constant; zero when no shift is applied.
    localparam logic signed [IN_W:0] RND =
        (SHIFT > 0) ? ({{IN_W{1'b0}}, 1'b1} << (SHIFT - 1)) : '0;

    // Output range limits, sign-extended to the IN_W+1 working width.
    localparam logic signed [IN_W:0] SMAX = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] SMIN = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    // ------------------------------------------------------------------
    // Decimation phase
    // ------------------------------------------------------------------
    logic [3:0] phase_q;
    logic [3:0] reload;
    logic       keep;

    // Keep decision and reload value; decim is only sampled at reload time.
    always_comb begin
        keep   = data_in_en && (phase_q == 4'd0);
        reload = (decim == 4'd0) ? 4'd0 : decim - 4'd1;
    end

    // Phase counter: reload on a kept sample, count down on discarded ones.
    always_ff @(posedge m_clk) begin
        if (rst) begin
            phase_q <= 4'd0;
        end else if (data_in_en) begin
            phase_q <= keep ? reload : phase_q - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: round, shift, saturate
    // ------------------------------------------------------------------
    logic signed [IN_W:0] rnd_sum;
    logic signed [IN_W:0] shifted;
    logic                 sat_hi;
    logic                 sat_lo;
    logic [OUT_W-1:0]     scaled;

    // Work one bit wider than the input so the rounding add can never wrap.
    always_comb begin
        rnd_sum = {data_in[IN_W-1], data_in} + RND;
        shifted = rnd_sum >>> SHIFT;
        sat_hi  = shifted > SMAX;
        sat_lo  = shifted < SMIN;
        if (sat_hi) begin
            scaled = SMAX[OUT_W-1:0];
        end else if (sat_lo) begin
            scaled = SMIN[OUT_W-1:0];
        end else begin
            scaled = shifted[OUT_W-1:0];
        end
    end

    logic             stg_v_q;
    logic             stg_sat_q;
    logic [OUT_W-1:0] stg_data_q;

    // Stage-1 register, loaded only for kept samples.
    always_ff @(posedge m_clk) begin
        if (rst) begin
            stg_v_q    <= 1'b0;
            stg_sat_q  <= 1'b0;
            stg_data_q <= '0;
        end else begin
            stg_v_q <= keep;
            if (keep) begin
                stg_sat_q  <= sat_hi || sat_lo;
                stg_data_q <= scaled;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             pop;
    logic             wr_ok;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    always_comb begin
        out_valid = (count_q != '0);
        out_data  = mem_q[rd_ptr_q];
        pop       = out_valid && out_ready;
        wr_ok     = stg_v_q && ((count_q < FULL_CNT) || pop);
        drop      = stg_v_q && !wr_ok;
        count_d   = count_q;
        if (wr_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge m_clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= stg_data_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a set in the same cycle as a clear wins
    // ------------------------------------------------------------------
    logic ovf_q;
    logic sat_q;

    // Overflow on any dropped write, saturation on any clamped sample leaving stage 1.
    always_ff @(posedge m_clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_flags) begin
                ovf_q <= 1'b0;
            end
            if (stg_v_q && stg_sat_q) begin
                sat_q <= 1'b1;
            end else if (clr_flags) begin
                sat_q <= 1'b0;
            end
        end
    end

    // Flag outputs come straight from their registers.
    always_comb begin
        ovf_flag = ovf_q;
        sat_flag = sat_q;
    end

endmodule

// File: tb/tb_fir_decim_sink.sv
// Directed, table-driven bench for fir_decim_sink with SHIFT=16, OUT_W=16.
module tb_fir_decim_sink;

    logic        m_clk = 1'b0;
    logic        rst;
    logic [3:0]  decim;
    logic        data_in_en;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        drop;
    logic        ovf_flag;
    logic        sat_flag;
    logic        clr_flags;

    int total = 0;
    int bad   = 0;
    int drop_cnt;
    logic [15:0] got[$];
    logic [15:0] exp_q[$];

    typedef struct {
        logic [31:0] din;
        logic [15:0] dout;
        logic        sat;
    } vec_t;

    vec_t tbl[9];

    always #5 m_clk = ~m_clk;

    fir_decim_sink #(
        .IN_W      (32),
        .OUT_W     (16),
        .SHIFT     (16),
        .FIFO_DEPTH(4)
    ) dut (
        .m_clk     (m_clk),
        .rst       (rst),
        .decim     (decim),
        .data_in_en(data_in_en),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop      (drop),
        .ovf_flag  (ovf_flag),
        .sat_flag  (sat_flag),
        .clr_flags (clr_flags)
    );

    // Record every pop and every drop cycle, sampled mid-cycle.
    always @(negedge m_clk) begin
        if (!rst) begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (drop) drop_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge m_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        data_in_en = 1'b0;
        clr_flags  = 1'b0;
        cyc();
        rst = 1'b0;
        got.delete();
        exp_q.delete();
        drop_cnt = 0;
    endtask

    task automatic strobe(input logic [31:0] d);
        data_in    = d;
        data_in_en = 1'b1;
        cyc();
        data_in_en = 1'b0;
    endtask

    task automatic check_drain(input string name);
        chk({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk(name, {16'h0, got[i]}, {16'h0, exp_q[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'h0000_8000, 16'h0001, 1'b0};
        tbl[1] = '{32'h0000_7FFF, 16'h0000, 1'b0};
        tbl[2] = '{32'hFFFF_8000, 16'h0000, 1'b0};
        tbl[3] = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1};
        tbl[4] = '{32'h8000_0000, 16'h8000, 1'b0};
        tbl[5] = '{32'h0003_0000, 16'h0003, 1'b0};
        tbl[6] = '{32'hFFFF_7FFF, 16'hFFFF, 1'b0};
        tbl[7] = '{32'h7FFF_8000, 16'h7FFF, 1'b1};
        tbl[8] = '{32'h7FFF_7FFF, 16'h7FFF, 1'b0};

        decim     = 4'd1;
        data_in   = '0;
        out_ready = 1'b1;
        drop_cnt  = 0;
        do_reset();

        // Reset values
        chk("rst_valid", {31'h0, out_valid}, 0);
        chk("rst_data", {16'h0, out_data}, 0);
        chk("rst_drop", {31'h0, drop}, 0);
        chk("rst_ovf", {31'h0, ovf_flag}, 0);
        chk("rst_sat", {31'h0, sat_flag}, 0);

        // decim=1, six back-to-back strobes, latency two edges
        decim     = 4'd1;
        out_ready = 1'b1;
        data_in_en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            data_in = 32'(k) << 16;
            cyc();
            if (k == 1) chk("lat_edge1", {31'h0, out_valid}, 0);
            if (k == 2) chk("lat_edge2", {31'h0, out_valid}, 1);
        end
        data_in_en = 1'b0;
        idle(4);
        for (int k = 1; k <= 6; k++) exp_q.push_back(16'(k));
        check_drain("stream1");
        chk("stream1_drops", drop_cnt, 0);
        chk("stream1_ovf", {31'h0, ovf_flag}, 0);
        chk("stream1_sat", {31'h0, sat_flag}, 0);

        // decim=3 on 0..8
        do_reset();
        decim = 4'd3;
        for (int k = 0; k <= 8; k++) strobe(32'(k) << 16);
        idle(4);
        exp_q = '{16'd0, 16'd3, 16'd6};
        check_drain("decim3");

        // decim 3 -> 2 mid-count: takes effect only at the next reload
        do_reset();
        decim = 4'd3;
        strobe(32'd0);
        strobe(32'd1 << 16);
        decim = 4'd2;
        for (int k = 2; k <= 9; k++) strobe(32'(k) << 16);
        idle(4);
        exp_q = '{16'd0, 16'd3, 16'd5, 16'd7, 16'd9};
        check_drain("decim_switch");

        // Rounding and saturation table
        for (int i = 0; i < 9; i++) begin
            do_reset();
            decim     = 4'd1;
            out_ready = 1'b1;
            strobe(tbl[i].din);
            cyc();
            chk($sformatf("tbl%0d_valid", i), {31'h0, out_valid}, 1);
            chk($sformatf("tbl%0d_data", i), {16'h0, out_data}, {16'h0, tbl[i].dout});
            chk($sformatf("tbl%0d_sat", i), {31'h0, sat_flag}, {31'h0, tbl[i].sat});
        end

        // Clear alone, then clear concurrent with a new saturation
        do_reset();
        strobe(32'h7FFF_FFFF);
        cyc();
        chk("sat_set", {31'h0, sat_flag}, 1);
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        chk("sat_cleared", {31'h0, sat_flag}, 0);
        strobe(32'h7FFF_FFFF);
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        chk("sat_set_wins", {31'h0, sat_flag}, 1);

        // Overflow: ready low, six strobes into a 4-deep FIFO
        do_reset();
        decim     = 4'd1;
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) strobe(32'(k) << 16);
        idle(3);
        chk("ovf_drops", drop_cnt, 2);
        chk("ovf_flag", {31'h0, ovf_flag}, 1);
        chk("ovf_head", {16'h0, out_data}, 1);
        out_ready = 1'b1;
        idle(6);
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd4};
        check_drain("ovf_drain");

        // Full FIFO with a simultaneous pop and write
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) strobe(32'(k) << 16);
        idle(2);
        chk("full_head", {16'h0, out_data}, 1);
        strobe(32'd5 << 16);
        out_ready = 1'b1;
        #1;
        chk("full_pop_nodrop", {31'h0, drop}, 0);
        cyc();
        out_ready = 1'b0;
        chk("full_pop_head", {16'h0, out_data}, 2);
        strobe(32'd6 << 16);
        #1;
        chk("full_still", {31'h0, drop}, 1);
        idle(2);
        chk("full_drops", drop_cnt, 1);
        out_ready = 1'b1;
        idle(6);
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        check_drain("full_drain");

        // Reset mid-stream: 3 buffered, stage 1 valid, phase non-zero
        do_reset();
        decim     = 4'd1;
        out_ready = 1'b0;
        strobe(32'd1 << 16);
        strobe(32'd2 << 16);
        strobe(32'd3 << 16);
        decim = 4'd4;
        strobe(32'd4 << 16);
        chk("mid_pre_valid", {31'h0, out_valid}, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_valid", {31'h0, out_valid}, 0);
        chk("mid_data", {16'h0, out_data}, 0);
        idle(2);
        chk("mid_stage_flushed", {31'h0, out_valid}, 0);
        strobe(32'd9 << 16);
        cyc();
        chk("mid_kept_valid", {31'h0, out_valid}, 1);
        chk("mid_kept_data", {16'h0, out_data}, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
